// File: rtl/simd_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : simd_pkg
//  Description : Shared types and default widths for the instruction
//                sequencer and decoder (sequencer state encoding, halt
//                opcode, address/opcode widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package simd_pkg;

    localparam int                        C_INS_ADDR_WIDTH = 8;
    localparam int                        C_OPCODE_WIDTH   = 3;
    localparam logic [C_OPCODE_WIDTH-1:0] C_HALT_OPCODE    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage : simd_pkg
`default_nettype wire

// File: rtl/ins_phase_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : ins_phase_cnt
//  Description : Execute-phase counter for one instruction. Counts
//                0..CYCLES_PER_INS-1 while advanced, holds otherwise, and
//                provides the registered half_clk phase plus first/last
//                cycle flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ins_phase_cnt #(
    parameter int CYCLES_PER_INS = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clr,
    input  logic i_adv,
    output logic o_half_clk,
    output logic o_first,
    output logic o_last
);

    localparam int            CW     = $clog2(CYCLES_PER_INS);
    localparam logic [CW-1:0] C_LAST = CW'(CYCLES_PER_INS - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CYCLES_PER_INS / 2);

    logic [CW-1:0] r_ex_cnt;
    logic          r_half_clk;
    logic [CW-1:0] w_ex_next;

    // The last cycle always clears rather than advances, so no wrap logic.
    assign w_ex_next  = r_ex_cnt + 1'b1;
    assign o_half_clk = r_half_clk;
    assign o_first    = (r_ex_cnt == '0);
    assign o_last     = (r_ex_cnt == C_LAST);

    // Phase counter: clear on entry/exit of EXEC, step on unstalled cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ex_cnt   <= '0;
            r_half_clk <= 1'b0;
        end else if (i_clr) begin
            r_ex_cnt   <= '0;
            r_half_clk <= 1'b0;
        end else if (i_adv) begin
            r_ex_cnt   <= w_ex_next;
            r_half_clk <= (w_ex_next >= C_HALF);
        end
    end

endmodule : ins_phase_cnt
`default_nettype wire

// File: rtl/ins_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ins_seq_ctrl
//  Description : Program sequencer for the instruction BRAM / decoder pair.
//                Issues pc, waits out BRAM read latency, paces each
//                instruction over CYCLES_PER_INS execute cycles and drives
//                half_clk, ins_valid and start/busy/done handshakes.
//                Optional macro INS_LOOP_EN adds loop_cnt: a HALT with a
//                nonzero remaining count restarts the program at the
//                captured start address instead of finishing.
//  Revision    : 1.0 - initial release
// ============================================================================
module ins_seq_ctrl
    import simd_pkg::*;
#(
    parameter int                      INS_ADDR_WIDTH = C_INS_ADDR_WIDTH,
    parameter int                      OPCODE_WIDTH   = C_OPCODE_WIDTH,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE    = C_HALT_OPCODE,
    parameter int                      BRAM_LATENCY   = 1,
    parameter int                      CYCLES_PER_INS = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [INS_ADDR_WIDTH-1:0] start_addr,
    input  logic                      stall,
    input  logic [OPCODE_WIDTH-1:0]   ins_opcode,
`ifdef INS_LOOP_EN
    input  logic [7:0]                loop_cnt,
`endif
    output logic [INS_ADDR_WIDTH-1:0] pc,
    output logic                      half_clk,
    output logic                      ins_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      pc_overflow
);

    localparam int            LW         = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;
    localparam logic [LW-1:0] C_LAT_LAST = LW'(BRAM_LATENCY - 1);

    seq_state_t                r_state;
    logic [INS_ADDR_WIDTH-1:0] r_pc;
    logic [LW-1:0]             r_lat_cnt;
    logic                      r_ins_valid;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_pc_overflow;
`ifdef INS_LOOP_EN
    logic [INS_ADDR_WIDTH-1:0] r_start_addr;
    logic [7:0]                r_loop_left;
`endif

    logic w_first;
    logic w_last;
    logic w_half_clk;
    logic w_exec_go;
    logic w_halt_now;
    logic w_ph_clr;
    logic w_ph_adv;

    // The opcode for pc is only visible during the first EXEC cycle, so the
    // decision taken at the end of that cycle drives the registered strobe,
    // which is therefore high in the following cycle. A stalled first cycle
    // simply postpones the sampling edge.
    assign w_exec_go  = (r_state == ST_EXEC) && !stall;
    assign w_halt_now = w_exec_go && w_first && (ins_opcode == HALT_OPCODE);
    assign w_ph_clr   = w_halt_now || (w_exec_go && w_last);
    assign w_ph_adv   = w_exec_go && !w_ph_clr;

    assign pc          = r_pc;
    assign half_clk    = w_half_clk;
    assign ins_valid   = r_ins_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pc_overflow = r_pc_overflow;

    ins_phase_cnt #(
        .CYCLES_PER_INS (CYCLES_PER_INS)
    ) u_phase (
        .clk        (clk),
        .rstn       (rstn),
        .i_clr      (w_ph_clr),
        .i_adv      (w_ph_adv),
        .o_half_clk (w_half_clk),
        .o_first    (w_first),
        .o_last     (w_last)
    );

    // Sequencer FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_lat_cnt     <= '0;
            r_ins_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pc_overflow <= 1'b0;
`ifdef INS_LOOP_EN
            r_start_addr  <= '0;
            r_loop_left   <= '0;
`endif
        end else begin
            r_ins_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pc          <= start_addr;
                        r_pc_overflow <= 1'b0;
                        r_lat_cnt     <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_FETCH;
`ifdef INS_LOOP_EN
                        r_start_addr  <= start_addr;
                        r_loop_left   <= loop_cnt;
`endif
                    end
                end
                ST_FETCH: begin
                    if (!stall) begin
                        if (r_lat_cnt == C_LAT_LAST) begin
                            r_lat_cnt <= '0;
                            r_state   <= ST_EXEC;
                        end else begin
                            r_lat_cnt <= r_lat_cnt + 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (w_halt_now) begin
`ifdef INS_LOOP_EN
                        if (r_loop_left != 8'd0) begin
                            r_loop_left <= r_loop_left - 8'd1;
                            r_pc        <= r_start_addr;
                            r_lat_cnt   <= '0;
                            r_state     <= ST_FETCH;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
`else
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
`endif
                    end else if (w_exec_go) begin
                        if (w_first) begin
                            r_ins_valid <= 1'b1;
                        end
                        if (w_last) begin
                            if (&r_pc) begin
                                r_pc_overflow <= 1'b1;
                                r_busy        <= 1'b0;
                                r_done        <= 1'b1;
                                r_state       <= ST_DONE;
                            end else begin
                                r_pc      <= r_pc + 1'b1;
                                r_lat_cnt <= '0;
                                r_state   <= ST_FETCH;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : ins_seq_ctrl
`default_nettype wire
